// File: rtl/display_arbiter_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
// Source codes, FSM states, the registered display payload and a clamp helper.
package display_arbiter_pkg;

    localparam int unsigned VAL_W         = 7;
    localparam int unsigned SRC_W         = 2;
    localparam int unsigned DIGIT_MAX_DEF = 99;

    localparam logic [SRC_W-1:0] SRC_SCORE = 2'd0;
    localparam logic [SRC_W-1:0] SRC_LEVEL = 2'd1;
    localparam logic [SRC_W-1:0] SRC_ALERT = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_SHOW_LEVEL = 2'd1,
        ST_SHOW_ALERT = 2'd2
    } state_t;

    typedef struct packed {
        logic [VAL_W-1:0] counter;
        logic [SRC_W-1:0] source;
        logic             blank;
        logic             busy;
    } disp_t;

    function automatic logic [VAL_W-1:0] clamp_val(input logic [VAL_W-1:0] v,
                                                    input logic [VAL_W-1:0] vmax);
        return (v > vmax) ? vmax : v;
    endfunction

endpackage

// File: rtl/display_hold_timer.sv
// Loadable down-counter that stops at zero and flags it.
// Used both for the display hold time and for the alert blink half-period.
module display_hold_timer #(
    parameter int unsigned WIDTH = 25
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             i_Load,
    input  logic [WIDTH-1:0] i_Load_Val,
    input  logic             i_Dec,
    output logic             o_Zero_c
);

    logic [WIDTH-1:0] r_Count;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_Count <= '0;
        end else if (i_Load) begin
            r_Count <= i_Load_Val;
        end else if (i_Dec && (r_Count != '0)) begin
            r_Count <= r_Count - WIDTH'(1);
        end
    end

    assign o_Zero_c = (r_Count == '0);

endmodule

// File: rtl/display_arbiter.sv
// Shares the two-digit display between live score, timed level number and
// timed blinking alert (highest priority); all outputs are registered.
module display_arbiter
    import display_arbiter_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES  = 25_000_000,
    parameter int unsigned BLINK_CYCLES = 6_250_000,
    parameter int unsigned DIGIT_MAX    = DIGIT_MAX_DEF
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic [VAL_W-1:0] i_Score,
    input  logic [VAL_W-1:0] i_Level,
    input  logic             i_Level_Stb,
    input  logic [VAL_W-1:0] i_Alert,
    input  logic             i_Alert_Stb,
    output logic [VAL_W-1:0] o_Counter,
    output logic [SRC_W-1:0] o_Source,
    output logic             o_Blank,
    output logic             o_Busy
);

    localparam int unsigned HOLD_W  = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
    localparam int unsigned BLINK_W = (BLINK_CYCLES > 2) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [VAL_W-1:0]   MAX_V      = VAL_W'(DIGIT_MAX);
    localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [BLINK_W-1:0] BLINK_LOAD = BLINK_W'(BLINK_CYCLES - 1);

    state_t           r_State;
    state_t           w_State_Nxt;
    disp_t            r_Disp;
    disp_t            w_Disp_Nxt;
    logic             r_Pend;
    logic             w_Pend_Nxt;
    logic [VAL_W-1:0] r_Pend_Val;
    logic [VAL_W-1:0] w_Pend_Val_Nxt;

    logic [VAL_W-1:0] w_Score_C;
    logic [VAL_W-1:0] w_Level_C;
    logic [VAL_W-1:0] w_Alert_C;
    logic [VAL_W-1:0] w_Enter_Val;
    logic             w_Enter_Alert;
    logic             w_Enter_Level;
    logic             w_Go_Idle;
    logic             w_Hold_Load;
    logic             w_Hold_Dec;
    logic             w_Hold_Zero;
    logic             w_Blink_Load;
    logic             w_Blink_Dec;
    logic             w_Blink_Zero;

    assign w_Score_C = clamp_val(i_Score, MAX_V);
    assign w_Level_C = clamp_val(i_Level, MAX_V);
    assign w_Alert_C = clamp_val(i_Alert, MAX_V);

    display_hold_timer #(.WIDTH(HOLD_W)) u_hold (
        .i_Clk      (i_Clk),
        .i_Rst      (i_Rst),
        .i_Load     (w_Hold_Load),
        .i_Load_Val (HOLD_LOAD),
        .i_Dec      (w_Hold_Dec),
        .o_Zero_c   (w_Hold_Zero)
    );

    display_hold_timer #(.WIDTH(BLINK_W)) u_blink (
        .i_Clk      (i_Clk),
        .i_Rst      (i_Rst),
        .i_Load     (w_Blink_Load),
        .i_Load_Val (BLINK_LOAD),
        .i_Dec      (w_Blink_Dec),
        .o_Zero_c   (w_Blink_Zero)
    );

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_State    <= ST_IDLE;
            r_Disp     <= '0;
            r_Pend     <= 1'b0;
            r_Pend_Val <= '0;
        end else begin
            r_State    <= w_State_Nxt;
            r_Disp     <= w_Disp_Nxt;
            r_Pend     <= w_Pend_Nxt;
            r_Pend_Val <= w_Pend_Val_Nxt;
        end
    end

    // Per-state decision first, then a shared block applies the chosen transition.
    always_comb begin
        w_State_Nxt    = r_State;
        w_Disp_Nxt     = r_Disp;
        w_Pend_Nxt     = r_Pend;
        w_Pend_Val_Nxt = r_Pend_Val;
        w_Enter_Alert  = 1'b0;
        w_Enter_Level  = 1'b0;
        w_Enter_Val    = w_Level_C;
        w_Go_Idle      = 1'b0;
        w_Hold_Load    = 1'b0;
        w_Hold_Dec     = 1'b0;
        w_Blink_Load   = 1'b0;
        w_Blink_Dec    = 1'b0;

        case (r_State)
            ST_IDLE: begin
                if (i_Alert_Stb)      w_Enter_Alert = 1'b1;
                else if (i_Level_Stb) w_Enter_Level = 1'b1;
                else                  w_Disp_Nxt.counter = w_Score_C;
            end
            ST_SHOW_LEVEL: begin
                if (i_Alert_Stb)      w_Enter_Alert = 1'b1;
                else if (i_Level_Stb) w_Enter_Level = 1'b1;
                else if (w_Hold_Zero) w_Go_Idle     = 1'b1;
                else                  w_Hold_Dec    = 1'b1;
            end
            ST_SHOW_ALERT: begin
                if (i_Alert_Stb) begin
                    w_Enter_Alert = 1'b1;
                end else if (w_Hold_Zero) begin
                    // A level strobe in the last alert cycle is newer than any pending one.
                    if (i_Level_Stb) begin
                        w_Enter_Level = 1'b1;
                    end else if (r_Pend) begin
                        w_Enter_Level = 1'b1;
                        w_Enter_Val   = r_Pend_Val;
                    end else begin
                        w_Go_Idle = 1'b1;
                    end
                end else begin
                    w_Hold_Dec = 1'b1;
                    if (i_Level_Stb) begin
                        w_Pend_Nxt     = 1'b1;
                        w_Pend_Val_Nxt = w_Level_C;
                    end
                    if (w_Blink_Zero) begin
                        w_Disp_Nxt.blank = ~r_Disp.blank;
                        w_Blink_Load     = 1'b1;
                    end else begin
                        w_Blink_Dec = 1'b1;
                    end
                end
            end
            default: w_Go_Idle = 1'b1;
        endcase

        if (w_Enter_Alert) begin
            w_State_Nxt  = ST_SHOW_ALERT;
            w_Disp_Nxt   = '{counter: w_Alert_C, source: SRC_ALERT, blank: 1'b0, busy: 1'b1};
            w_Hold_Load  = 1'b1;
            w_Blink_Load = 1'b1;
            if (i_Level_Stb) begin
                w_Pend_Nxt     = 1'b1;
                w_Pend_Val_Nxt = w_Level_C;
            end
        end else if (w_Enter_Level) begin
            w_State_Nxt = ST_SHOW_LEVEL;
            w_Disp_Nxt  = '{counter: w_Enter_Val, source: SRC_LEVEL, blank: 1'b0, busy: 1'b1};
            w_Hold_Load = 1'b1;
            w_Pend_Nxt  = 1'b0;
        end else if (w_Go_Idle) begin
            w_State_Nxt = ST_IDLE;
            w_Disp_Nxt  = '{counter: w_Score_C, source: SRC_SCORE, blank: 1'b0, busy: 1'b0};
        end
    end

    assign o_Counter = r_Disp.counter;
    assign o_Source  = r_Disp.source;
    assign o_Blank   = r_Disp.blank;
    assign o_Busy    = r_Disp.busy;

endmodule

// File: tb/tb_display_arbiter.sv
// Directed plus random stimulus for display_arbiter, checked every cycle
// against a timeline model (source, remaining cycles, age, pending slot).
module tb_display_arbiter;

    localparam int unsigned HOLD  = 8;
    localparam int unsigned BLINK = 2;
    localparam int unsigned DMAX  = 99;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] score, lvl, alert;
    logic       lvl_stb, alert_stb;
    logic [6:0] o_counter;
    logic [1:0] o_source;
    logic       o_blank, o_busy;

    int checks   = 0;
    int failures = 0;

    int m_src, m_val, m_left, m_age, m_pend, m_pv;

    always #5 clk = ~clk;

    display_arbiter #(
        .HOLD_CYCLES (HOLD),
        .BLINK_CYCLES(BLINK),
        .DIGIT_MAX   (DMAX)
    ) dut (
        .i_Clk      (clk),
        .i_Rst      (rst),
        .i_Score    (score),
        .i_Level    (lvl),
        .i_Level_Stb(lvl_stb),
        .i_Alert    (alert),
        .i_Alert_Stb(alert_stb),
        .o_Counter  (o_counter),
        .o_Source   (o_source),
        .o_Blank    (o_blank),
        .o_Busy     (o_busy)
    );

    function automatic int clamp(input int v);
        return (v > int'(DMAX)) ? int'(DMAX) : v;
    endfunction

    task automatic show(input int src, input int val);
        m_src  = src;
        m_val  = val;
        m_left = int'(HOLD);
        m_age  = 0;
        if (src == 1) m_pend = 0;
    endtask

    // Advances the display timeline by one clock edge using the sampled inputs.
    task automatic model_step();
        if (rst) begin
            m_src = 0; m_val = 0; m_left = 0; m_age = 0; m_pend = 0; m_pv = 0;
        end else if (alert_stb) begin
            if (lvl_stb) begin m_pend = 1; m_pv = clamp(int'(lvl)); end
            show(2, clamp(int'(alert)));
        end else if (lvl_stb && m_src == 2 && m_left > 1) begin
            m_pend = 1; m_pv = clamp(int'(lvl));
            m_left--; m_age++;
        end else if (lvl_stb) begin
            show(1, clamp(int'(lvl)));
        end else if (m_src != 0 && m_left == 1) begin
            if (m_src == 2 && m_pend != 0) show(1, m_pv);
            else begin m_src = 0; m_val = clamp(int'(score)); end
        end else if (m_src == 0) begin
            m_val = clamp(int'(score));
        end else begin
            m_left--; m_age++;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, act, exp);
        end
    endtask

    task automatic verify();
        check("counter", 32'(o_counter), 32'(m_val));
        check("source",  32'(o_source),  32'(m_src));
        check("blank",   32'(o_blank),   32'((m_src == 2) && (((m_age / int'(BLINK)) % 2) == 1)));
        check("busy",    32'(o_busy),    32'(m_src != 0));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        verify();
        rst       = 1'b0;
        lvl_stb   = 1'b0;
        alert_stb = 1'b0;
    endtask

    initial begin
        rst = 1'b1; score = 7'd42; lvl = '0; alert = '0; lvl_stb = 1'b0; alert_stb = 1'b0;
        m_src = 0; m_val = 0; m_left = 0; m_age = 0; m_pend = 0; m_pv = 0;

        // Reset with strobes present: they must be ignored.
        lvl_stb = 1'b1; alert_stb = 1'b1; rst = 1'b1;
        tick();
        check("reset_counter", 32'(o_counter), 32'd0);
        tick();
        check("score42", 32'(o_counter), 32'd42);
        score = 7'd120;
        tick();
        check("score_clamp", 32'(o_counter), 32'd99);
        score = 7'd17;

        // Level hold for exactly HOLD cycles.
        lvl = 7'd7; lvl_stb = 1'b1;
        tick();
        check("level_src", 32'(o_source), 32'd1);
        repeat (HOLD) tick();
        check("level_done", 32'(o_source), 32'd0);

        // Alert blink pattern then idle.
        alert = 7'd55; alert_stb = 1'b1;
        repeat (HOLD + 2) tick();

        // Simultaneous strobes: alert first, then queued level.
        alert = 7'd3; lvl = 7'd9; alert_stb = 1'b1; lvl_stb = 1'b1;
        tick();
        repeat (HOLD) tick();
        check("pending_level", 32'(o_counter), 32'd9);
        repeat (HOLD + 1) tick();

        // Alert preempts a level, which is not resumed.
        lvl = 7'd4; lvl_stb = 1'b1;
        repeat (3) tick();
        alert = 7'd11; alert_stb = 1'b1;
        repeat (HOLD + 3) tick();

        // Reset mid-alert with a pending level clears everything.
        alert = 7'd127; alert_stb = 1'b1;
        tick();
        check("alert_clamp", 32'(o_counter), 32'd99);
        lvl = 7'd33; lvl_stb = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        check("rst_busy", 32'(o_busy), 32'd0);
        repeat (HOLD + 2) tick();

        // Strobes landing in the final hold cycle.
        lvl = 7'd21; lvl_stb = 1'b1;
        repeat (HOLD) tick();
        lvl = 7'd22; lvl_stb = 1'b1;
        repeat (HOLD) tick();
        alert = 7'd66; alert_stb = 1'b1;
        repeat (HOLD) tick();
        lvl = 7'd77; lvl_stb = 1'b1;
        repeat (HOLD + 2) tick();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            score     = 7'($urandom_range(0, 127));
            lvl       = 7'($urandom_range(0, 127));
            alert     = 7'($urandom_range(0, 127));
            lvl_stb   = ($urandom_range(0, 9) == 0);
            alert_stb = ($urandom_range(0, 13) == 0);
            rst       = ($urandom_range(0, 199) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
